counter_updn_mod: RTL
=====================

// Module: counter_updn_mod
// PURPOSE
//  Parametrised synchronous up/down counter with a programmable modulus. Next
//  generation of the team's 4-bit loadable counter, adding width, direction,
//  synchronous clear and terminal-count wrap at a runtime top value.
//  Cascadable through ENP/ENT/RCO. Used for clock dividers, event counters and
//  address sequencers in the counter test chips.
// PARAMETERS
//  WIDTH     8            counter width in bits, legal range 2..16
//  TOP_RST   {WIDTH{1'b1}} value of the internal top register after reset
// PORTS
//  CLK      in   1      clock, rising edge active
//  nCLR     in   1      asynchronous active-low reset
//  nSCLR    in   1      synchronous clear, active low
//  nLOAD    in   1      synchronous parallel load, active low
//  Din      in   WIDTH  parallel load value
//  nTLOAD   in   1      synchronous load of the top register from Din, active low
//  UP       in   1      direction: 1 = count up, 0 = count down
//  ENP      in   1      count enable (parallel)
//  ENT      in   1      count enable (trickle); also gates RCO
//  Dout     out  WIDTH  counter value (registered)
//  TC       out  1      terminal count: UP ? (Dout==top) : (Dout==0); combinational
//  RCO      out  1      ripple carry = TC & ENT; combinational
//  CMP      in   WIDTH  compare value (CNT_CMP_EN only)
//  MATCH    out  1      registered compare flag (CNT_CMP_EN only)
// BEHAVIOUR
//  - Reset: nCLR=0 forces cnt=0 and top=TOP_RST immediately. The reset does not
//    wait for CLK. Dout=0. TC=!UP || TOP_RST==0. RCO=TC&ENT. MATCH=0.
//  - The counter and top register update on the rising CLK edge only. They have
//    the following priority, highest first:
//    1. nSCLR=0: cnt<=0. nSCLR also blocks any counting in that cycle.
//    2. nLOAD=0: cnt<=Din.
//    3. ENP&ENT, UP=1: if cnt>=top then cnt<=0, else cnt<=cnt+1.
//    4. ENP&ENT, UP=0: if cnt==0 then cnt<=top, else cnt<=cnt-1.
//    5. Otherwise cnt holds.
//  - Top register: nTLOAD=0 sets top<=Din on the clock edge. This happens
//    independently of, and in the same cycle as, any cnt update. The cnt
//    update in that cycle uses the old top.
//  - Simultaneous nLOAD=0 and nTLOAD=0: both registers take Din.
//  - Loaded value above top:
//    - UP=1 wraps to 0 on the next count.
//    - UP=0 decrements normally until it reaches 0, then reloads top.
//  - top==0: the counter stays at 0 in both directions, and TC=1 constantly.
//  - Arithmetic is modulo 2^WIDTH. No other state exists.
//  - The counter is a single-state machine; there is no FSM.
//  - Latency: a count, load or clear is visible on Dout 1 cycle after the edge.
//    TC and RCO follow Dout, UP and ENT combinationally in the same cycle.
//  - Cascade: connect RCO of stage n to ENT of stage n+1. Share ENP across all
//    stages. All stages must share UP.
//  - Reset mid-count: asynchronous nCLR drops Dout to 0 at once. Counting
//    resumes on the first edge after nCLR is released.
// CONFIGURATION
//  - Macro CNT_CMP_EN defined:
//    - Adds the CMP input and the MATCH output.
//    - MATCH<=(cnt_next==CMP) on every edge, where cnt_next is the value cnt
//      takes at that edge. So MATCH==(Dout==CMP) without a cycle of lag.
//    - A change on CMP takes effect at the next edge.
//    - MATCH is 0 during nCLR=0.
//  - Macro CNT_CMP_EN undefined:
//    - CMP and MATCH are absent from the port list.
//    - No compare logic is built.
//    - All other behaviour is identical.
// TESTING
//  1. WIDTH=4: reset, then ENP=ENT=UP=1 for 17 clocks.
//     -> Dout runs 0..15 then 0. RCO=1 only while Dout=15.
//  2. WIDTH=8: nTLOAD=0 with Din=9, then count up 12 clocks.
//     -> Dout runs 0..9,0,1. TC high at 9.
//     Then set UP=0. -> Dout runs 1,0,9,8.
//  3. top=9, nLOAD=0 with Din=200, UP=1, count.
//     -> Dout 200 then 0.
//     Same with UP=0. -> Dout 200,199,...
//  4. nSCLR=0, nLOAD=0 and ENP=ENT=1 in the same cycle -> Dout=0.
//     nLOAD=0 with ENP=0 -> Dout=Din.
//     ENT=0 -> Dout holds and RCO=0.
//  5. Two WIDTH=4 stages cascaded, full range, up-count 255 clocks from 0.
//     -> combined value is 0xFF. High-stage RCO is high only at 0xFF.
//     Assert nCLR mid-count -> both stages read 0 before the next edge.
//  6. CNT_CMP_EN defined, CMP=5, counting up.
//     -> MATCH high exactly while Dout=5.
//     Change CMP to 7 -> MATCH follows from the next edge.

Source files
------------

// File: rtl/counter_updn_mod.sv
// counter_updn_mod
//   Synchronous up/down counter with a runtime top value (modulus).
//   The counter wraps at top when counting up and reloads top when counting
//   down through zero. Stages cascade through ENP/ENT/RCO.
//   Optional feature: define CNT_CMP_EN to add the CMP input and the
//   registered MATCH output.
//   Reset: nCLR, asynchronous, active low. Clock: CLK, rising edge.

module counter_updn_mod #(
    parameter int              WIDTH   = 8,
    parameter logic [WIDTH-1:0] TOP_RST = {WIDTH{1'b1}}
) (
    input  logic             CLK,
    input  logic             nCLR,
    input  logic             nSCLR,
    input  logic             nLOAD,
    input  logic [WIDTH-1:0] Din,
    input  logic             nTLOAD,
    input  logic             UP,
    input  logic             ENP,
    input  logic             ENT,
    output logic [WIDTH-1:0] Dout,
    output logic             TC,
    output logic             RCO
`ifdef CNT_CMP_EN
    ,
    input  logic [WIDTH-1:0] CMP,
    output logic             MATCH
`endif
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] top;
    logic             count_en;

    assign count_en = ENP & ENT;

    // Next counter value.
    // Priority, highest first: sync clear, parallel load, count, hold.
    // Counting always compares against the current top. A top load in the
    // same cycle only affects later cycles.
    always_comb begin
        cnt_next = cnt;
        if (!nSCLR) begin
            cnt_next = '0;
        end else if (!nLOAD) begin
            cnt_next = Din;
        end else if (count_en) begin
            if (UP) begin
                // >= rather than == so that a value loaded above top
                // still wraps to 0 on the next count.
                cnt_next = (cnt >= top) ? '0 : cnt + WIDTH'(1);
            end else begin
                cnt_next = (cnt == '0) ? top : cnt - WIDTH'(1);
            end
        end
    end

    // Counter register. The reset is asynchronous.
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

    // Top register. It loads from Din independently of the counter update.
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            top <= TOP_RST;
        end else if (!nTLOAD) begin
            top <= Din;
        end
    end

    assign Dout = cnt;

    // Terminal count depends on direction. With top == 0 both terms hold.
    assign TC  = UP ? (cnt == top) : (cnt == '0);
    assign RCO = TC & ENT;

`ifdef CNT_CMP_EN
    // MATCH is registered from cnt_next, so it lines up with Dout
    // without a cycle of lag.
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            MATCH <= 1'b0;
        end else begin
            MATCH <= (cnt_next == CMP);
        end
    end
`endif

endmodule
